// File: rtl/dragon_spawn_scheduler_if.sv
// Launch-side signal bundle between the spawn scheduler, the frame/RNG sources and the dragon movers.
`timescale 1ns/1ps
interface dragon_spawn_scheduler_if #(
  parameter int N_DRAGONS = 4
);
  logic                 startOfFrame;
  logic                 pause;
  logic [10:0]          RNG;
  logic [N_DRAGONS-1:0] slotBusy;
  logic [N_DRAGONS-1:0] spawnAck;
  logic [N_DRAGONS-1:0] spawnReq;
  logic [10:0]          spawnY;
  logic [3:0]           activeCount;
  logic                 cooldown;

  // The scheduler issues launch requests, so it is the master side.
  modport master (
    input  startOfFrame, pause, RNG, slotBusy, spawnAck,
    output spawnReq, spawnY, activeCount, cooldown
  );

  modport slave (
    output startOfFrame, pause, RNG, slotBusy, spawnAck,
    input  spawnReq, spawnY, activeCount, cooldown
  );
endinterface

// File: rtl/dragon_spawn_scheduler.sv
// Once-per-frame dragon launch sequencer: cooldown, RNG launch window, round-robin slot pick, req/ack with timeout.
// Optional macro DRAGON_SPAWN_BURST_EN halves the cooldown after a launch made while no dragon was active.
`timescale 1ns/1ps
module dragon_spawn_scheduler #(
  parameter int N_DRAGONS      = 4,
  parameter int MAX_ACTIVE     = 3,
  parameter int MIN_GAP_FRAMES = 30,
  parameter int WIN_LO         = 550,
  parameter int WIN_HI         = 605,
  parameter int Y_MIN          = 20,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  dragon_spawn_scheduler_if.master bus
);

  localparam int PTR_W = $clog2(N_DRAGONS);

  localparam logic [10:0]          WIN_LO_C     = 11'(WIN_LO);
  localparam logic [10:0]          WIN_HI_C     = 11'(WIN_HI);
  localparam logic [10:0]          Y_MIN_C      = 11'(Y_MIN);
  localparam logic [3:0]           MAX_ACTIVE_C = 4'(MAX_ACTIVE);
  localparam logic [7:0]           GAP_FULL     = 8'(MIN_GAP_FRAMES);
  localparam logic [7:0]           ACK_LAST     = 8'(ACK_TIMEOUT - 1);
  localparam logic [N_DRAGONS-1:0] REQ_LSB      = {{(N_DRAGONS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    COOLDOWN,
    ARMED,
    SELECT,
    REQUEST
  } state_e;

  state_e               state_q,       state_d;
  logic [7:0]           gap_cnt_q,     gap_cnt_d;
  logic [N_DRAGONS-1:0] spawn_req_q,   spawn_req_d;
  logic [10:0]          spawn_y_q,     spawn_y_d;
  logic [PTR_W-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [PTR_W-1:0]     slot_q,        slot_d;
  logic [7:0]           ack_timer_q,   ack_timer_d;
  logic [3:0]           active_count_q;

  logic [3:0]           busy_count;
  logic                 free_found;
  logic [PTR_W-1:0]     free_slot;
  logic [PTR_W-1:0]     scan_idx;
  logic                 launch_ok;
  logic [7:0]           gap_reload;

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < N_DRAGONS; i++) begin
      busy_count = busy_count + {3'b000, bus.slotBusy[i]};
    end
  end

  // First free slot at or after the round-robin pointer, wrapping around.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_DRAGONS; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % N_DRAGONS);
      if (!free_found && !bus.slotBusy[scan_idx]) begin
        free_found = 1'b1;
        free_slot  = scan_idx;
      end
    end
  end

  assign launch_ok = bus.startOfFrame && !bus.pause
                  && (bus.RNG > WIN_LO_C) && (bus.RNG < WIN_HI_C)
                  && (active_count_q < MAX_ACTIVE_C)
                  && !(&bus.slotBusy);

`ifdef DRAGON_SPAWN_BURST_EN
  localparam logic [7:0] GAP_BURST = ((MIN_GAP_FRAMES >> 1) < 1) ? 8'd1 : 8'(MIN_GAP_FRAMES >> 1);
  assign gap_reload = (active_count_q == 4'd0) ? GAP_BURST : GAP_FULL;
`else
  assign gap_reload = GAP_FULL;
`endif

  always_comb begin
    // NOTE: every next-state value starts as "hold" so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    spawn_req_d = spawn_req_q;
    spawn_y_d   = spawn_y_q;
    rr_ptr_d    = rr_ptr_q;
    slot_d      = slot_q;
    ack_timer_d = ack_timer_q;

    unique case (state_q)
      COOLDOWN: begin
        if (bus.startOfFrame && !bus.pause) begin
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_d = '0;
            state_d   = ARMED;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
      end

      ARMED: begin
        if (launch_ok) state_d = SELECT;
      end

      SELECT: begin
        spawn_y_d = Y_MIN_C + {4'b0000, bus.RNG[6:0]};
        if (free_found) begin
          spawn_req_d = REQ_LSB << free_slot;
          slot_d      = free_slot;
          ack_timer_d = '0;
          state_d     = REQUEST;
        end else begin
          state_d     = ARMED;
        end
      end

      REQUEST: begin
        if (bus.spawnAck[slot_q]) begin
          spawn_req_d = '0;
          rr_ptr_d    = PTR_W'((int'(slot_q) + 1) % N_DRAGONS);
          gap_cnt_d   = gap_reload;
          state_d     = COOLDOWN;
        end else if (ack_timer_q == ACK_LAST) begin
          spawn_req_d = '0;
          state_d     = ARMED;
        end else begin
          ack_timer_d = ack_timer_q + 8'd1;
        end
      end

      default: state_d = COOLDOWN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= COOLDOWN;
      gap_cnt_q      <= GAP_FULL;
      spawn_req_q    <= '0;
      spawn_y_q      <= Y_MIN_C;
      rr_ptr_q       <= '0;
      slot_q         <= '0;
      ack_timer_q    <= '0;
      active_count_q <= '0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      spawn_req_q    <= spawn_req_d;
      spawn_y_q      <= spawn_y_d;
      rr_ptr_q       <= rr_ptr_d;
      slot_q         <= slot_d;
      ack_timer_q    <= ack_timer_d;
      active_count_q <= busy_count;
    end
  end

  assign bus.spawnReq    = spawn_req_q;
  assign bus.spawnY      = spawn_y_q;
  assign bus.activeCount = active_count_q;
  assign bus.cooldown    = (state_q == COOLDOWN);

endmodule

// File: tb/tb_dragon_spawn_scheduler.sv
// Directed bench for dragon_spawn_scheduler: launch timing, rotation, window bounds, timeout, pause, cooldown reload.
`timescale 1ns/1ps
module tb_dragon_spawn_scheduler;

  localparam int N = 4;
`ifdef DRAGON_SPAWN_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;

  dragon_spawn_scheduler_if #(.N_DRAGONS(N)) bus ();

  dragon_spawn_scheduler #(
    .N_DRAGONS(N), .MAX_ACTIVE(3), .MIN_GAP_FRAMES(30), .WIN_LO(550),
    .WIN_HI(605), .Y_MIN(20), .ACK_TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected gap after an ack, given the active count seen in the ack cycle.
  function automatic int reload_for(input int cnt);
    return (BURST && cnt == 0) ? 15 : 30;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic wait_cooldown(input string tag, input int n);
    frames(n - 1);
    check({tag, "_still_cool"}, 32'(bus.cooldown), 32'd1);
    frames(1);
    check({tag, "_armed"}, 32'(bus.cooldown), 32'd0);
  endtask

  // startOfFrame pulse, then the SELECT cycle; leaves sampling at the first REQUEST cycle.
  task automatic attempt();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
  endtask

  task automatic ack(input logic [N-1:0] a);
    bus.spawnAck = a;
    tick();
    bus.spawnAck = '0;
  endtask

  task automatic req_width(output int cycles);
    int  guard;
    cycles = (bus.spawnReq != '0) ? 1 : 0;
    guard  = 0;
    while (bus.spawnReq != '0 && guard < 40) begin
      tick();
      guard++;
      if (bus.spawnReq != '0) cycles++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.startOfFrame = 1'b0;
    bus.pause        = 1'b0;
    bus.RNG          = 11'd600;
    bus.slotBusy     = 4'b1111;
    bus.spawnAck     = '0;

    // Reset values, held even though every slot reports busy.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",      32'(bus.spawnReq),    32'd0);
    check("rst_y",        32'(bus.spawnY),      32'd20);
    check("rst_active",   32'(bus.activeCount), 32'd0);
    check("rst_cooldown", 32'(bus.cooldown),    32'd1);
    bus.slotBusy = 4'b0000;
    resetN = 1'b1;
    tick();

    // First launch after 30 frames: slot 0, row 20+88.
    wait_cooldown("gap0", 30);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("l1_select_no_req", 32'(bus.spawnReq), 32'd0);
    tick();
    check("l1_req", 32'(bus.spawnReq), 32'b0001);
    check("l1_y",   32'(bus.spawnY),   32'd108);
    ack(4'b0001);
    check("l1_req_drop", 32'(bus.spawnReq), 32'd0);
    check("l1_cooldown", 32'(bus.cooldown), 32'd1);
    bus.slotBusy = 4'b0001;

    // Rotation: slot 1, then slot 2.
    wait_cooldown("gap1", reload_for(0));
    attempt();
    check("l2_req", 32'(bus.spawnReq), 32'b0010);
    ack(4'b0010);
    bus.slotBusy = 4'b0011;

    wait_cooldown("gap2", reload_for(1));
    attempt();
    check("l3_req", 32'(bus.spawnReq), 32'b0100);
    ack(4'b0100);
    bus.slotBusy = 4'b0111;
    tick();
    check("active3", 32'(bus.activeCount), 32'd3);

    // MAX_ACTIVE reached: armed but no launch.
    wait_cooldown("gap3", reload_for(2));
    attempt();
    tick();
    check("blocked_req",   32'(bus.spawnReq), 32'd0);
    check("blocked_armed", 32'(bus.cooldown), 32'd0);

    // activeCount lags slotBusy by one cycle.
    bus.slotBusy = 4'b0011;
    check("lag_old", 32'(bus.activeCount), 32'd3);
    tick();
    check("lag_new", 32'(bus.activeCount), 32'd2);

    // rrPtr=3 and slot 3 free: request slot 3, withhold ack -> 16-cycle request then ARMED.
    attempt();
    check("to1_req", 32'(bus.spawnReq), 32'b1000);
    check("to1_y",   32'(bus.spawnY),   32'd108);
    req_width(w);
    check("to1_width", 32'(w), 32'd16);
    check("to1_armed", 32'(bus.cooldown), 32'd0);

    // rrPtr unchanged after timeout: slot 3 still chosen over free slot 0.
    bus.slotBusy = 4'b0110;
    tick();
    attempt();
    check("to2_req", 32'(bus.spawnReq), 32'b1000);
    req_width(w);
    check("to2_width", 32'(w), 32'd16);

    // Slot 3 busy: scan wraps to slot 0.
    bus.slotBusy = 4'b1010;
    tick();
    attempt();
    check("wrap_req", 32'(bus.spawnReq), 32'b0001);
    ack(4'b0001);
    bus.slotBusy = 4'b0000;

    // Launch window bounds are exclusive.
    wait_cooldown("gap4", reload_for(2));
    bus.RNG = 11'd550;
    attempt();
    tick();
    check("win_lo_req", 32'(bus.spawnReq), 32'd0);
    bus.RNG = 11'd605;
    attempt();
    tick();
    check("win_hi_req", 32'(bus.spawnReq), 32'd0);
    bus.RNG = 11'd551;
    attempt();
    check("win_551_req", 32'(bus.spawnReq), 32'b0010);
    check("win_551_y",   32'(bus.spawnY),   32'd59);
    ack(4'b0010);

    // Paused frames do not count down the cooldown.
    bus.RNG   = 11'd600;
    bus.pause = 1'b1;
    frames(10);
    check("pause_cool", 32'(bus.cooldown), 32'd1);
    bus.pause = 1'b0;
    wait_cooldown("gap5", reload_for(0));

    // Pause blocks arming but not an in-flight request.
    bus.pause = 1'b1;
    attempt();
    tick();
    check("pause_block_req", 32'(bus.spawnReq), 32'd0);
    bus.pause = 1'b0;
    attempt();
    check("pr_req", 32'(bus.spawnReq), 32'b0100);
    bus.pause = 1'b1;
    tick();
    tick();
    check("pr_held", 32'(bus.spawnReq), 32'b0100);
    ack(4'b0100);
    check("pr_drop", 32'(bus.spawnReq), 32'd0);
    bus.pause = 1'b0;

    // Gap after an ack with nothing active: 15 frames with burst, 30 without.
    wait_cooldown("burst_gap", reload_for(0));
    attempt();
    check("burst_req", 32'(bus.spawnReq), 32'b1000);
    ack(4'b1000);
    check("burst_drop", 32'(bus.spawnReq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
